bcd2bin: RTL and testbench
==========================

BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of packed BCD digits per input word.
REQ-002 SHALL have parameter WIDTH, default 10: binary result width; WIDTH >= ceil(log2(10^DIGITS)) for valid input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  bcd holds a word to convert.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port bcd  input  4*DIGITS  packed BCD; digit 0 in bits [3:0] (units).
REQ-008 SHALL have port out_valid  output  1  bin holds a completed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port bin  output  WIDTH  binary result.
REQ-011 SHALL have port err  output  1  a digit of the converted word was > 9; qualified by out_valid.

Function
REQ-012 SHALL implement an FSM with states IDLE, CONV, DONE.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid 0; in CONV and DONE, in_ready SHALL be 0.
REQ-014 On in_valid && in_ready, SHALL capture bcd into an internal register, clear accumulator and digit counter, and enter CONV.
REQ-015 In CONV, each cycle SHALL compute acc <= acc*10 + digit, MS digit first; acc*10 = (acc<<3)+(acc<<1), truncated to WIDTH.
REQ-016 After exactly DIGITS CONV cycles, SHALL enter DONE with bin = final acc; out_valid asserts DIGITS cycles after the accepting edge.
REQ-017 In DONE, out_valid SHALL be 1; bin and err SHALL stay stable until out_valid && out_ready.
REQ-018 On out_valid && out_ready, SHALL return to IDLE; the next word is accepted no earlier than the following edge (throughput one word per DIGITS+2 cycles minimum).
REQ-019 in_valid and bcd changes during CONV/DONE SHALL have no effect on the result in progress.
REQ-020 Arithmetic overflow SHALL wrap modulo 2^WIDTH; no saturation.
REQ-021 bin SHALL equal 0 whenever out_valid is 0.

Reset
REQ-022 While rst = 0, SHALL asynchronously force state IDLE, accumulator 0, counter 0, bin 0, err 0, out_valid 0.
REQ-023 in_ready SHALL be 1 in the first cycle after rst releases.
REQ-024 Reset asserted in CONV or DONE SHALL abort the conversion; no out_valid for the aborted word.

Configuration
REQ-025 Macro BCD2BIN_ERR_EN SHALL select digit-range checking.
REQ-026 With BCD2BIN_ERR_EN defined, err SHALL be set in DONE if any captured digit exceeded 9; conversion still follows REQ-015 (e.g. 0x0A5 -> 105).
REQ-027 Without BCD2BIN_ERR_EN, err SHALL be tied to 0 and no checking logic SHALL be present; bin behaviour unchanged.

Verification
REQ-028 Reset release, bcd=0x999, in_valid one cycle, out_ready=1 -> out_valid after 3 cycles, bin=999, err=0, then in_ready=1.
REQ-029 bcd=0x000 and bcd=0x001 back-to-back -> bin=0 then bin=1; second accept only after first output handshake.
REQ-030 bcd=0x472, out_ready=0 for 5 cycles -> out_valid held, bin=472 stable, in_ready=0; release -> IDLE next edge.
REQ-031 Accept bcd=0x123, assert rst low in 2nd CONV cycle -> all outputs 0 immediately, no out_valid; after release, 0x058 -> bin=58.
REQ-032 With BCD2BIN_ERR_EN: bcd=0x0A5 -> bin=105, err=1; bcd=0x105 -> err=0. Without macro: 0x0A5 -> bin=105, err=0.
REQ-033 Toggle bcd and in_valid randomly during CONV of 0x256 -> bin=256 unaffected.

Source files
------------

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to binary converter: one digit per cycle, MS digit first.
// Define BCD2BIN_ERR_EN to flag captured digits above 9 on err.
module bcd2bin #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    bin,
    output logic                err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q,   bcd_d;
    logic [WIDTH-1:0]    acc_q,   acc_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [3:0]          digit;

    // The captured word shifts left each CONV cycle, so the top nibble is always the next digit.
    assign digit = bcd_q[4*DIGITS-1 -: 4];

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bcd_d   = bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + WIDTH'(digit);
                bcd_d = bcd_q << 4;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BCD2BIN_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && in_valid) err_d = 1'b0;
        else if (state_q == CONV)        err_d = err_q | (digit > 4'd9);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = out_valid & err_q;
`else
    assign err = 1'b0;
`endif

    // in_ready is masked while reset is held so every output reads 0 during reset.
    assign in_ready  = (state_q == IDLE) & rst;
    assign out_valid = (state_q == DONE);
    assign bin       = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: vector table, scoreboard on the output handshake,
// plus hand sequences for back-pressure, input scrambling and reset abort.
module tb_bcd2bin;

    localparam int DIGITS = 3;
    localparam int WIDTH  = 10;
`ifdef BCD2BIN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [WIDTH-1:0]    bin;
    logic                err;

    bcd2bin #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
    } vec_t;

    typedef struct {
        logic [9:0] bin;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: compare whenever a result is handed to the consumer.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_bin", 32'(bin), 32'(e.bin));
                check("sb_err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic do_word(input logic [11:0] word, input logic [9:0] exp_bin,
                           input logic exp_err, input int hold, input bit scramble);
        int   lat;
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bcd       = word;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        e.bin = exp_bin;
        e.err = ERR_EN ? exp_err : 1'b0;
        sb_q.push_back(e);
        in_valid = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 10) break;
            check("conv_in_ready", 32'(in_ready), 0);
            check("conv_bin_zero", 32'(bin), 0);
            @(posedge clk);
            #1;
            lat++;
            if (scramble) begin
                in_valid = 1'($urandom);
                bcd      = 12'($urandom);
            end
        end
        in_valid = 1'b0;
        check("latency", lat, DIGITS);
        if (!out_valid) return;
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_bin", 32'(bin), 32'(exp_bin));
            check("hold_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            if (h == hold - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_out_valid", 32'(out_valid), 0);
        check("idle_bin_zero", 32'(bin), 0);
    endtask

    vec_t vecs[12];

    initial begin
        int stray;

        vecs[0]  = '{12'h999, 10'd999, 1'b0};
        vecs[1]  = '{12'h000, 10'd0,   1'b0};
        vecs[2]  = '{12'h001, 10'd1,   1'b0};
        vecs[3]  = '{12'h0A5, 10'd105, 1'b1};
        vecs[4]  = '{12'h105, 10'd105, 1'b0};
        vecs[5]  = '{12'h123, 10'd123, 1'b0};
        vecs[6]  = '{12'hFFF, 10'd641, 1'b1};  // 1665 mod 1024
        vecs[7]  = '{12'hA00, 10'd1000, 1'b1};
        vecs[8]  = '{12'hB00, 10'd76,  1'b1};  // 1100 mod 1024
        vecs[9]  = '{12'h058, 10'd58,  1'b0};
        vecs[10] = '{12'h00A, 10'd10,  1'b1};
        vecs[11] = '{12'h090, 10'd90,  1'b0};

        // Outputs while reset is held.
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_bin", 32'(bin), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);

        foreach (vecs[i]) do_word(vecs[i].bcd, vecs[i].bin, vecs[i].err, 0, 1'b0);

        // Back-pressure: result held for five cycles.
        do_word(12'h472, 10'd472, 1'b0, 5, 1'b0);

        // Input noise during conversion must not disturb the result.
        do_word(12'h256, 10'd256, 1'b0, 0, 1'b1);

        // Reset in the second CONV cycle aborts the word.
        @(negedge clk);
        bcd      = 12'h123;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_bin", 32'(bin), 0);
        check("abort_err", 32'(err), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_release_ready", 32'(in_ready), 1);
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("abort_no_output", stray, 0);
        do_word(12'h058, 10'd58, 1'b0, 0, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
